pipe_beat_packer: RTL
=====================

Name: pipe_beat_packer

Overview:
- Width up-converter that sits directly downstream of pipe_skid_buffer on a valid/ready stream.
- Packs RATIO consecutive DWIDTH-bit input beats into one DWIDTH*RATIO-bit output word.
- i_last closes a partial word early; o_keep marks the populated lanes.
- Output is registered, so the block also serves as a pipeline stage toward wide consumers such as a memory-write or bus packer.

Parameters:
- DWIDTH, 8, width of one input beat (one lane).
- RATIO, 4, input beats per output word; legal range 2..16.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_data  input  DWIDTH  input beat.
- i_valid  input  1  input beat valid.
- i_last  input  1  beat is last of packet; closes the current word.
- i_ready  output  1  block accepts the input beat this cycle.
- o_data  output  DWIDTH*RATIO  packed word; lane k = bits [k*DWIDTH +: DWIDTH].
- o_keep  output  RATIO  bit k set means lane k holds valid data.
- o_last  output  1  word contains the i_last beat.
- o_valid  output  1  output word valid.
- o_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (rst=1, asynchronous assert, released synchronously by the system):
  - o_valid=0, o_data=0, o_keep=0, o_last=0.
  - Lane counter cnt=0; accumulator and its keep mask cleared.
- Handshake:
  - Input transfer occurs when i_valid && i_ready.
  - Output transfer occurs when o_valid && o_ready.
- i_ready = !o_valid || o_ready (combinational). The o_ready to i_ready path is intentional; the upstream skid buffer breaks it.
- Once o_valid=1, o_data, o_keep and o_last hold stable until the output transfer. o_valid never drops without a transfer.
- Accepted beat, non-completing (cnt < RATIO-1 and i_last=0):
  - Write i_data into accumulator lane cnt, set keep bit cnt, cnt <= cnt+1.
- Accepted beat, completing (cnt == RATIO-1 or i_last=1):
  - Next cycle: o_data = accumulator with lane cnt replaced by i_data; o_keep = accumulated keep | (1<<cnt); o_last = i_last; o_valid = 1.
  - Same edge: accumulator and keep cleared, cnt <= 0.
- Latency: o_valid asserts on the clock edge that accepts the completing beat, i.e. the word is visible the cycle after that beat.
- Lane ordering: first beat of a word goes in lane 0 (LSBs). Lanes not written in a partial word read 0 with keep bit 0.
- Throughput: with o_ready held 1, one beat is accepted every cycle with no bubbles. Word N+1 loads into the output register on the same edge word N is consumed.
- Backpressure: while o_valid=1 and o_ready=0, i_ready=0. No beat is accepted, even a non-completing one, and the accumulator holds.
- i_last with cnt==RATIO-1: one full word, o_keep all ones, o_last=1.
- i_last on the first beat: o_keep = 1, o_last = 1, other lanes 0.
- i_valid=0: no state change except the output drain.
- i_data and i_last are ignored when i_valid=0.
- Reset mid-word or mid-stall: the partial word and the pending output word are discarded. Outputs return to reset values immediately (asynchronous).
- cnt width = clog2(RATIO). Never exceeds RATIO-1; no wrap beyond that.

Test Plan:
- Reset then stream 0x01..0x08, i_last on 0x08, o_ready=1 → two words: o_data=0x04030201 with o_keep=0xF, o_last=0; then o_data=0x08070605 with o_keep=0xF, o_last=1. Second word appears exactly 4 cycles after the first; i_ready constant 1.
- Partial word: beats 0xAA, 0xBB, then 0xCC with i_last → o_data=0x00CCBBAA, o_keep=0x7, o_last=1. Single-beat packet 0x5A with i_last → o_data=0x0000005A, o_keep=0x1.
- Backpressure: complete word 0x44332211 while o_ready=0 for 5 cycles, i_valid held with 0x55 → o_valid stays 1, o_data stable, i_ready=0 throughout. 0x55 is accepted the cycle o_ready rises and lands in lane 0 of the next word.
- Randomised o_ready (per-cycle random, as in existing benches), 55 sequential bytes with i_last every 7th beat → scoreboard shows no loss, duplication or reordering. o_keep/o_last are correct per packet, e.g. packet 1 yields 0x04030201 with keep 0xF, then 0x00070605 with keep 0x7 and o_last=1.
- Reset asserted after 2 beats of a word and again while a word is stalled → outputs zero immediately. The next stream after release starts at lane 0; no stale lanes appear.
- Parameter sweep DWIDTH=16, RATIO=2 → beats 0x1111, 0x2222 give o_data=0x22221111, o_keep=0x3.

Source files
------------

// File: rtl/pipe_beat_packer.sv
// pipe_beat_packer: packs RATIO narrow valid/ready beats into one wide
// registered output word. i_last closes a partial word early, and o_keep
// marks which lanes of that word hold data.
`timescale 1ns/1ps
module pipe_beat_packer #(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DWIDTH-1:0]         i_data,
    input  logic                      i_valid,
    input  logic                      i_last,
    output logic                      i_ready,
    output logic [DWIDTH*RATIO-1:0]   o_data,
    output logic [RATIO-1:0]          o_keep,
    output logic                      o_last,
    output logic                      o_valid,
    input  logic                      o_ready
);

    localparam int WW = DWIDTH * RATIO;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

    // Lane counter and the partially filled word
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WW-1:0]    acc_q,      acc_d;
    logic [RATIO-1:0] acc_keep_q, acc_keep_d;

    // Registered output word
    logic [WW-1:0]    data_q,  data_d;
    logic [RATIO-1:0] keep_q,  keep_d;
    logic             last_q,  last_d;
    logic             valid_q, valid_d;

    logic [RATIO-1:0] lane_sel;
    logic [WW-1:0]    merged_data;
    logic [RATIO-1:0] merged_keep;
    logic             accept;
    logic             complete;

    // The upstream skid buffer breaks this combinational o_ready path.
    assign i_ready  = !valid_q || o_ready;
    assign accept   = i_valid && i_ready;
    assign complete = accept && (i_last || (cnt_q == CNT_MAX));

    // Accumulator with the incoming beat dropped into lane cnt_q
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        assign lane_sel[gi] = (cnt_q == CW'(gi));
        assign merged_data[gi*DWIDTH +: DWIDTH] =
            lane_sel[gi] ? i_data : acc_q[gi*DWIDTH +: DWIDTH];
    end
    assign merged_keep = acc_keep_q | lane_sel;

    // Next-state: drain the output register, then either grow the
    // accumulator or promote the merged word into the output register.
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        valid_d    = valid_q;

        if (valid_q && o_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                data_d     = merged_data;
                keep_d     = merged_keep;
                last_d     = i_last;
                valid_d    = 1'b1;
                acc_d      = '0;
                acc_keep_d = '0;
                cnt_d      = '0;
            end else begin
                acc_d      = merged_data;
                acc_keep_d = merged_keep;
                cnt_d      = cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset discards both the partial and pending words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_keep  = keep_q;
    assign o_last  = last_q;
    assign o_valid = valid_q;

endmodule
